// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage sequencer: operation codes,
// sequencer states, MEM/WB mux select bit positions and op-class helpers.
package mem_stage_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_PASS8  = 3'd1,
    OP_PASS16 = 3'd2,
    OP_LD8    = 3'd3,
    OP_LD16   = 3'd4,
    OP_SFR_RD = 3'd5,
    OP_ST8    = 3'd6,
    OP_ST16   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC_LO,
    ST_ACC_HI,
    ST_COMPLETE
  } state_e;

  localparam int unsigned SEL_LD_BOT  = 0;
  localparam int unsigned SEL_SFR_TOP = 1;
  localparam int unsigned SEL_EX_TOP  = 2;
  localparam int unsigned SEL_LD_TOP  = 3;

  function automatic logic is_mem_op(input op_e op);
    return (op == OP_LD8) || (op == OP_LD16) || (op == OP_ST8) || (op == OP_ST16);
  endfunction

  function automatic logic is_load(input op_e op);
    return (op == OP_LD8) || (op == OP_LD16);
  endfunction

  function automatic logic is_store(input op_e op);
    return (op == OP_ST8) || (op == OP_ST16);
  endfunction

  function automatic logic is_wide(input op_e op);
    return (op == OP_LD16) || (op == OP_ST16);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_wait_timer.sv
// mem_wait_timer: 8-bit saturating wait counter for the memory handshake.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : restart the count at zero (has priority over enable)
//   enable       : current cycle is an unacknowledged request cycle
//   expired      : this enabled cycle brings the count to MAX_WAIT
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The register holds completed wait cycles, so the MAX_WAIT-th unacked
  // cycle is the one that sees MAX_WAIT-1 and aborts in that same cycle.
  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage sequencer. Decodes the EX/MEM op, runs
// the byte-wide data-memory handshake (16-bit accesses split into two bytes),
// captures load bytes, drives the MEM/WB data mux selects and stalls.
//   clock, reset                 : clock, synchronous active-high reset
//   op_valid, op, addr           : instruction from EX/MEM
//   st_data_top, st_data_bot     : store data bytes
//   mem_req/we/addr/wdata        : memory request
//   mem_ack, mem_rdata           : memory acknowledge and read data
//   sfr_rd_en                    : SFR read strobe
//   ld_res_top, ld_res_bot       : registered load bytes
//   sel_signals                  : MEM/WB mux selects
//   stall, wb_valid, bus_err     : pipeline freeze, writeback valid, abort flag
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            st_data_top,
  input  logic [7:0]            st_data_bot,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  sfr_rd_en,
  output logic [7:0]            ld_res_top,
  output logic [7:0]            ld_res_bot,
  output logic [3:0]            sel_signals,
  output logic                  stall,
  output logic                  wb_valid,
  output logic                  bus_err
);

  state_e                state_q, state_d;
  op_e                   op_in, op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            top_q, bot_q;
  logic                  err_q;
  logic                  expired, abort;

  assign op_in = op_e'(op);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (mem_req && !mem_ack),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sfr_rd_en   = 1'b0;
    sel_signals = '0;
    stall       = 1'b0;
    wb_valid    = 1'b0;
    bus_err     = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_in)
            OP_PASS8: wb_valid = 1'b1;
            OP_PASS16: begin
              sel_signals[SEL_EX_TOP] = 1'b1;
              wb_valid                = 1'b1;
            end
            OP_SFR_RD: begin
              sel_signals[SEL_SFR_TOP] = 1'b1;
              sfr_rd_en                = 1'b1;
              wb_valid                 = 1'b1;
            end
            OP_LD8, OP_LD16, OP_ST8, OP_ST16: begin
              stall   = 1'b1;
              state_d = ST_ACC_LO;
            end
            default: ;
          endcase
        end
      end
      ST_ACC_LO, ST_ACC_HI: begin
        mem_req  = 1'b1;
        stall    = 1'b1;
        mem_we   = is_store(op_q);
        mem_addr = (state_q == ST_ACC_HI) ? addr_q + ADDR_WIDTH'(1) : addr_q;
        if (is_store(op_q)) begin
          mem_wdata = (state_q == ST_ACC_HI) ? top_q : bot_q;
        end
        if (mem_ack) begin
          state_d = (state_q == ST_ACC_LO && is_wide(op_q)) ? ST_ACC_HI : ST_COMPLETE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        bus_err = err_q;
        state_d = ST_IDLE;
        if (op_q == OP_LD8) begin
          sel_signals[SEL_LD_BOT] = 1'b1;
          wb_valid                = 1'b1;
        end else if (op_q == OP_LD16) begin
          sel_signals[SEL_LD_BOT] = 1'b1;
          sel_signals[SEL_LD_TOP] = 1'b1;
          wb_valid                = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      top_q      <= '0;
      bot_q      <= '0;
      err_q      <= 1'b0;
      ld_res_top <= '0;
      ld_res_bot <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (op_valid && is_mem_op(op_in)) begin
            op_q   <= op_in;
            addr_q <= addr;
            top_q  <= st_data_top;
            bot_q  <= st_data_bot;
            err_q  <= 1'b0;
          end
        end
        ST_ACC_LO: begin
          if (mem_ack) begin
            if (is_load(op_q)) ld_res_bot <= mem_rdata;
            if (op_q == OP_LD8) ld_res_top <= '0;
          end else if (abort) begin
            err_q <= 1'b1;
            // Neither byte has arrived yet.
            if (is_load(op_q)) begin
              ld_res_bot <= '0;
              ld_res_top <= '0;
            end
          end
        end
        ST_ACC_HI: begin
          if (mem_ack) begin
            if (is_load(op_q)) ld_res_top <= mem_rdata;
          end else if (abort) begin
            err_q <= 1'b1;
            if (is_load(op_q)) ld_res_top <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [15:0] addr;
  logic [7:0]  st_data_top, st_data_bot;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        sfr_rd_en;
  logic [7:0]  ld_res_top, ld_res_bot;
  logic [3:0]  sel_signals;
  logic        stall, wb_valid, bus_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  mem_stage_ctrl #(.ADDR_WIDTH(16), .MAX_WAIT(15)) dut (
    .clock       (clock),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .addr        (addr),
    .st_data_top (st_data_top),
    .st_data_bot (st_data_bot),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .sfr_rd_en   (sfr_rd_en),
    .ld_res_top  (ld_res_top),
    .ld_res_bot  (ld_res_bot),
    .sel_signals (sel_signals),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .bus_err     (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs may then be changed and outputs sampled
  // well clear of the rising edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  int unsigned n_req;

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; addr = '0;
    st_data_top = '0; st_data_bot = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_req",   mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_wb",    wb_valid, 0);
    check("rst_err",   bus_err, 0);
    check("rst_sfr",   sfr_rd_en, 0);
    check("rst_sel",   sel_signals, 0);
    check("rst_ldres", {ld_res_top, ld_res_bot}, 16'h0000);

    // LD8 presented with op_valid low must not start an access.
    op = 3'd3; #1;
    check("idle_nov_stall", stall, 0);
    step();
    check("idle_nov_req", mem_req, 0);

    // LD16 @0x1230, ack on first request cycle each byte.
    op_valid = 1'b1; op = 3'd4; addr = 16'h1230; #1;
    check("ld16_idle_stall", stall, 1);
    check("ld16_idle_req", mem_req, 0);
    step();
    check("ld16_lo_req", mem_req, 1);
    check("ld16_lo_addr", mem_addr, 16'h1230);
    check("ld16_lo_we", mem_we, 0);
    check("ld16_lo_stall", stall, 1);
    mem_ack = 1'b1; mem_rdata = 8'h34;
    step();
    check("ld16_hi_addr", mem_addr, 16'h1231);
    check("ld16_hi_stall", stall, 1);
    mem_rdata = 8'h12;
    step();
    mem_ack = 1'b0; #1;
    check("ld16_cmp_stall", stall, 0);
    check("ld16_cmp_req", mem_req, 0);
    check("ld16_cmp_sel", sel_signals, 4'b1001);
    check("ld16_cmp_wb", wb_valid, 1);
    check("ld16_cmp_err", bus_err, 0);
    check("ld16_ldres", {ld_res_top, ld_res_bot}, 16'h1234);
    op_valid = 1'b0;
    step();

    // ST16 @0xFFFF, data AB/CD, two wait cycles before each ack.
    op_valid = 1'b1; op = 3'd7; addr = 16'hFFFF; st_data_top = 8'hAB; st_data_bot = 8'hCD;
    step();
    addr = 16'h5555; st_data_bot = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check("st16_lo_req", mem_req, 1);
      check("st16_lo_addr", mem_addr, 16'hFFFF);
      check("st16_lo_we", mem_we, 1);
      check("st16_lo_wdata", mem_wdata, 8'hCD);
      if (i == 2) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      check("st16_hi_req", mem_req, 1);
      check("st16_hi_addr", mem_addr, 16'h0000);
      check("st16_hi_wdata", mem_wdata, 8'hAB);
      check("st16_hi_stall", stall, 1);
      if (i == 2) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    #1;
    check("st16_cmp_sel", sel_signals, 4'b0000);
    check("st16_cmp_wb", wb_valid, 0);
    check("st16_cmp_stall", stall, 0);
    check("st16_cmp_req", mem_req, 0);
    op_valid = 1'b0;
    step();

    // LD8 with no ack: 15 request cycles, then abort.
    op_valid = 1'b1; op = 3'd3; addr = 16'h0040;
    step();
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      n_req++;
      step();
    end
    check("to_req_cycles", n_req, 15);
    check("to_cmp_err", bus_err, 1);
    check("to_cmp_bot", ld_res_bot, 8'h00);
    check("to_cmp_sel", sel_signals, 4'b0001);
    op_valid = 1'b0;
    step();
    check("to_err_1cyc", bus_err, 0);

    // LD8 acked on the 15th wait cycle: ack wins.
    op_valid = 1'b1; op = 3'd3; addr = 16'h0041;
    step();
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        check("lim_req15", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
      end
      step();
    end
    mem_ack = 1'b0; #1;
    check("lim_err", bus_err, 0);
    check("lim_bot", ld_res_bot, 8'h5A);
    check("lim_top", ld_res_top, 8'h00);
    check("lim_sel", sel_signals, 4'b0001);
    op_valid = 1'b0;
    step();

    // SFR_RD, PASS16, NOP, PASS8 back to back.
    op_valid = 1'b1; op = 3'd5; #1;
    check("sfr_sel", sel_signals, 4'b0010);
    check("sfr_en", sfr_rd_en, 1);
    check("sfr_wb", wb_valid, 1);
    check("sfr_stall", stall, 0);
    step();
    op = 3'd2; #1;
    check("p16_sel", sel_signals, 4'b0100);
    check("p16_sfr", sfr_rd_en, 0);
    check("p16_wb", wb_valid, 1);
    check("p16_stall", stall, 0);
    step();
    op = 3'd0; #1;
    check("nop_sel", sel_signals, 4'b0000);
    check("nop_wb", wb_valid, 0);
    check("nop_stall", stall, 0);
    step();
    op = 3'd1; #1;
    check("p8_sel", sel_signals, 4'b0000);
    check("p8_wb", wb_valid, 1);
    op_valid = 1'b0;
    step();

    // Reset during ACC_HI of LD16, late ack ignored, then a clean LD8.
    op_valid = 1'b1; op = 3'd4; addr = 16'h2000;
    step();
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    check("rstm_hi_addr", mem_addr, 16'h2001);
    reset = 1'b1; op_valid = 1'b0;
    step();
    reset = 1'b0; #1;
    check("rstm_req", mem_req, 0);
    check("rstm_stall", stall, 0);
    check("rstm_ldres", {ld_res_top, ld_res_bot}, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    step();
    mem_ack = 1'b0; #1;
    check("late_ack_req", mem_req, 0);
    check("late_ack_ldres", {ld_res_top, ld_res_bot}, 16'h0000);
    op_valid = 1'b1; op = 3'd3; addr = 16'h0010;
    step();
    check("post_ld8_addr", mem_addr, 16'h0010);
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    step();
    mem_ack = 1'b0; #1;
    check("post_ld8_bot", ld_res_bot, 8'hC3);
    check("post_ld8_sel", sel_signals, 4'b0001);
    check("post_ld8_wb", wb_valid, 1);
    op_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
